qint_sched: RTL and testbench

- Shares one qint interrupt channel among NSRC internal interrupt sources (disk controller, status/error, etc.) in the QSIC.
- Latches request pulses from each source and picks one by round-robin.
- Pulses qint's interrupt_request, then presents the winner's vector while qint asserts assert_vector during the IAK cycle.
- On completion, acknowledges the winning source and arbitrates again.

---
 rtl/qint_sched.sv | 174 +++++++++++++++++
 tb/tb_qint_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qint_sched.sv
// Shares one qint interrupt channel among NSRC internal sources: latches request pulses,
// picks a winner round-robin, runs the REQ/WAIT/DRIVE handshake and acknowledges the winner.
module qint_sched #(
    parameter int NSRC    = 4,
    parameter int VWIDTH  = 9,
    parameter int TIMEOUT = 1023
) (
    input  logic                   qclk,
    input  logic                   reset,
    input  logic [NSRC-1:0]        src_req,
    input  logic [NSRC*VWIDTH-1:0] src_vector,
    output logic [NSRC-1:0]        src_ack,
    output logic                   interrupt_request,
    input  logic                   assert_vector,
    output logic [VWIDTH-1:0]      vector_out,
    output logic [NSRC-1:0]        pending,
    output logic                   busy
);

    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // QBUS vectors are longword aligned: bits <1:0> never reach the bus.
    localparam logic [VWIDTH-1:0] VEC_MASK = {{(VWIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRIVE = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t            state_r, state_next_s;
    logic [NSRC-1:0]   pending_r;
    logic [PW-1:0]     rr_r, rr_next_s;
    logic [PW-1:0]     grant_r, grant_next_s;
    logic [PW-1:0]     pick_s;
    logic [PW:0]       grant_inc_s;
    logic [VWIDTH-1:0] vec_q_r, vec_next_s, vec_sel_s;
    logic [VWIDTH-1:0] vout_r, vout_next_s;
    logic [TW-1:0]     timer_r, timer_next_s;
    logic              irq_r, irq_next_s;
    logic [NSRC-1:0]   src_ack_r, ack_next_s;
    logic              busy_r;

    // First set request at or after start, wrapping modulo NSRC.
    function automatic logic [PW-1:0] rr_pick(input logic [NSRC-1:0] req,
                                              input logic [PW-1:0]   start);
        logic [PW-1:0] win;
        logic [PW:0]   idx;
        logic          found;
        win   = start;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            idx = {1'b0, start} + (PW+1)'(k);
            idx = (idx >= (PW+1)'(NSRC)) ? (idx - (PW+1)'(NSRC)) : idx;
            if (!found && req[idx[PW-1:0]]) begin
                win   = idx[PW-1:0];
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

    assign pick_s      = rr_pick(pending_r, rr_r);
    assign grant_inc_s = {1'b0, grant_r} + {{PW{1'b0}}, 1'b1};

    // Vector of the source that would win arbitration this cycle.
    always_comb begin
        vec_sel_s = {VWIDTH{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            vec_sel_s = (pick_s == PW'(i)) ? src_vector[i*VWIDTH +: VWIDTH] : vec_sel_s;
        end
    end

    // Next-state and next-output decode for the service handshake.
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_r;
        vec_next_s   = vec_q_r;
        timer_next_s = timer_r;
        rr_next_s    = rr_r;
        irq_next_s   = 1'b0;
        ack_next_s   = {NSRC{1'b0}};
        vout_next_s  = {VWIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (pending_r != {NSRC{1'b0}}) begin
                    grant_next_s = pick_s;
                    vec_next_s   = vec_sel_s & VEC_MASK;
                    irq_next_s   = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                timer_next_s = {TW{1'b0}};
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (assert_vector) begin
                    vout_next_s  = vec_q_r;
                    state_next_s = ST_DRIVE;
                end else if (timer_r == TW'(TIMEOUT)) begin
                    irq_next_s   = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    timer_next_s = timer_r + TW'(1);
                end
            end
            ST_DRIVE: begin
                if (assert_vector) begin
                    vout_next_s = vec_q_r;
                end else begin
                    for (int i = 0; i < NSRC; i++) begin
                        ack_next_s[i] = (grant_r == PW'(i));
                    end
                    rr_next_s    = (grant_inc_s >= (PW+1)'(NSRC)) ? {PW{1'b0}} : grant_inc_s[PW-1:0];
                    state_next_s = ST_GAP;
                end
            end
            ST_GAP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Service state and registered handshake outputs.
    always_ff @(posedge qclk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            grant_r   <= {PW{1'b0}};
            rr_r      <= {PW{1'b0}};
            vec_q_r   <= {VWIDTH{1'b0}};
            vout_r    <= {VWIDTH{1'b0}};
            timer_r   <= {TW{1'b0}};
            irq_r     <= 1'b0;
            src_ack_r <= {NSRC{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            grant_r   <= grant_next_s;
            rr_r      <= rr_next_s;
            vec_q_r   <= vec_next_s;
            vout_r    <= vout_next_s;
            timer_r   <= timer_next_s;
            irq_r     <= irq_next_s;
            src_ack_r <= ack_next_s;
            busy_r    <= (state_next_s != ST_IDLE);
        end
    end

    // Request latch; a new pulse in the acknowledge cycle beats the clear.
    always_ff @(posedge qclk or posedge reset) begin
        if (reset) begin
            pending_r <= {NSRC{1'b0}};
        end else begin
            pending_r <= (pending_r & ~src_ack_r) | src_req;
        end
    end

    assign src_ack           = src_ack_r;
    assign interrupt_request = irq_r;
    assign vector_out        = vout_r;
    assign pending           = pending_r;
    assign busy              = busy_r;

endmodule

// File: tb/tb_qint_sched.sv
// Bench for qint_sched: cycle table, directed handshake sequences and a randomized run
// against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_qint_sched;

    logic        qclk = 1'b0;
    logic        reset;
    logic [3:0]  src_req;
    logic [35:0] src_vector;
    logic [3:0]  src_ack;
    logic        interrupt_request;
    logic        assert_vector;
    logic [8:0]  vector_out;
    logic [3:0]  pending;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    qint_sched #(.NSRC(4), .VWIDTH(9), .TIMEOUT(8)) dut (
        .qclk(qclk), .reset(reset), .src_req(src_req), .src_vector(src_vector),
        .src_ack(src_ack), .interrupt_request(interrupt_request),
        .assert_vector(assert_vector), .vector_out(vector_out),
        .pending(pending), .busy(busy)
    );

    always #25 qclk = ~qclk;

    typedef struct {
        logic [3:0] req;
        logic       av;
        logic       irq;
        logic [3:0] ack;
        logic [8:0] vout;
        logic [3:0] pend;
        logic       bsy;
    } row_t;

    row_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge qclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src_req = 4'b0000;
        assert_vector = 1'b0;
        @(posedge qclk);
        @(posedge qclk);
        #1 reset = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic [8:0] v);
        src_vector[i*9 +: 9] = v;
    endtask

    task automatic wait_irq();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (interrupt_request) ok = 1'b1;
            else step();
        end
        chk("irq_wait", {31'd0, ok}, 32'd1);
    endtask

    // Current cycle is a WAIT cycle: drive assert_vector for len cycles and check delivery.
    task automatic drive_svc(input int src, input logic [8:0] vec, input int len,
                             input logic [3:0] inj, input logic [3:0] inj_ack);
        assert_vector = 1'b1;
        src_req = inj;
        for (int i = 0; i < len; i++) begin
            step();
            src_req = 4'b0000;
            if (i == len - 1) assert_vector = 1'b0;
            chk("svc_vout", {23'd0, vector_out}, {23'd0, vec});
            chk("svc_no_irq", {31'd0, interrupt_request}, 32'd0);
        end
        step();
        chk("svc_ack", {28'd0, src_ack}, 32'd1 << src);
        chk("svc_vout_off", {23'd0, vector_out}, 32'd0);
        chk("svc_busy_gap", {31'd0, busy}, 32'd1);
        src_req = inj_ack;
        step();
        src_req = 4'b0000;
        chk("svc_ack_once", {28'd0, src_ack}, 32'd0);
    endtask

    task automatic serve(input int src, input logic [8:0] vec, input int len,
                         input logic [3:0] inj, input logic [3:0] inj_ack);
        wait_irq();
        step();
        drive_svc(src, vec, len, inj, inj_ack);
    endtask

    function automatic int rr_scan(input logic [3:0] p, input int start);
        int w;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            if (w < 0 && p[(start + k) % 4]) w = (start + k) % 4;
        end
        return w;
    endfunction

    // Randomized run: the model tracks pending requests per cycle and the bench's own
    // handshake schedule; the winner comes from a round-robin scan at decision time.
    task automatic run_random(input int ncyc);
        logic [3:0]  pend_m, pend_prev, req_c, ack_e;
        logic [35:0] vec_prev;
        logic [63:0] r64;
        logic [8:0]  vsel, vout_e;
        logic        irq_e, busy_e;
        int idle_since, t_irq, t_s, t_ack, len, win, rr;
        bit active;
        do_reset();
        pend_m = 4'b0000; pend_prev = 4'b0000; vec_prev = src_vector;
        idle_since = 0; active = 1'b0; rr = 0; win = 0;
        t_irq = -100; t_s = -100; t_ack = -100; len = 1; vsel = 9'd0;
        for (int n = 0; n < ncyc; n++) begin
            irq_e = 1'b0; ack_e = 4'b0000; vout_e = 9'd0; busy_e = 1'b0;
            if (!active && (n - 1) >= idle_since && pend_prev != 4'b0000) begin
                win    = rr_scan(pend_prev, rr);
                vsel   = vec_prev[win*9 +: 9] & 9'h1FC;
                t_irq  = n;
                t_s    = n + 1 + int'($urandom_range(6, 0));
                len    = int'($urandom_range(4, 1));
                t_ack  = t_s + len + 1;
                active = 1'b1;
            end
            if (active) begin
                busy_e = 1'b1;
                irq_e  = (n == t_irq);
                vout_e = (n > t_s && n <= t_s + len) ? vsel : 9'd0;
                ack_e  = (n == t_ack) ? (4'b0001 << win) : 4'b0000;
            end
            chk("rnd_irq",  {31'd0, interrupt_request}, {31'd0, irq_e});
            chk("rnd_ack",  {28'd0, src_ack}, {28'd0, ack_e});
            chk("rnd_vout", {23'd0, vector_out}, {23'd0, vout_e});
            chk("rnd_pend", {28'd0, pending}, {28'd0, pend_m});
            chk("rnd_busy", {31'd0, busy}, {31'd0, busy_e});
            for (int b = 0; b < 4; b++) req_c[b] = ($urandom_range(5, 0) == 0);
            src_req = req_c;
            assert_vector = active && n >= t_s && n < t_s + len;
            if ($urandom_range(3, 0) == 0) begin
                r64 = {$urandom(), $urandom()};
                src_vector = r64[35:0];
            end
            if (active && n == t_ack) begin
                active = 1'b0;
                rr = (win + 1) % 4;
                idle_since = n + 1;
            end
            pend_prev = pend_m;
            pend_m    = (pend_m & ~ack_e) | req_c;
            vec_prev  = src_vector;
            step();
        end
        src_req = 4'b0000;
        assert_vector = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 9'o000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 9'o000, 4'b0100, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 9'o000, 4'b0100, 1'b1};
        tbl[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 9'o000, 4'b0100, 1'b1};
        tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 9'o330, 4'b0100, 1'b1};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 9'o330, 4'b0100, 1'b1};
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 9'o330, 4'b0100, 1'b1};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 9'o330, 4'b0100, 1'b1};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 9'o000, 4'b0100, 1'b1};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 9'o000, 4'b0000, 1'b0};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 9'o000, 4'b0000, 1'b0};
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 9'o000, 4'b0000, 1'b0};

        reset = 1'b1; src_req = 4'b0000; assert_vector = 1'b0; src_vector = 36'd0;
        #200;
        chk("rst_irq",  {31'd0, interrupt_request}, 32'd0);
        chk("rst_ack",  {28'd0, src_ack}, 32'd0);
        chk("rst_vout", {23'd0, vector_out}, 32'd0);
        chk("rst_pend", {28'd0, pending}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Single source, cycle by cycle.
        set_vec(2, 9'o330);
        do_reset();
        for (int r = 0; r < 12; r++) begin
            chk("tbl_irq",  {31'd0, interrupt_request}, {31'd0, tbl[r].irq});
            chk("tbl_ack",  {28'd0, src_ack}, {28'd0, tbl[r].ack});
            chk("tbl_vout", {23'd0, vector_out}, {23'd0, tbl[r].vout});
            chk("tbl_pend", {28'd0, pending}, {28'd0, tbl[r].pend});
            chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[r].bsy});
            src_req = tbl[r].req;
            assert_vector = tbl[r].av;
            step();
        end
        src_req = 4'b0000; assert_vector = 1'b0;

        // Round-robin fairness.
        do_reset();
        set_vec(0, 9'o100); set_vec(3, 9'o200); set_vec(1, 9'o110);
        src_req = 4'b1001;
        step();
        src_req = 4'b0000;
        serve(0, 9'o100, 2, 4'b0000, 4'b0000);
        chk("rr_pend_after0", {28'd0, pending}, 32'h8);
        serve(3, 9'o200, 3, 4'b0001, 4'b0000);
        serve(0, 9'o100, 1, 4'b0000, 4'b0000);
        chk("rr_pend_empty", {28'd0, pending}, 32'd0);
        src_req = 4'b0011;
        step();
        src_req = 4'b0000;
        serve(1, 9'o110, 1, 4'b0000, 4'b0000);
        serve(0, 9'o100, 1, 4'b0000, 4'b0000);

        // Timeout re-pulse every TIMEOUT+2 cycles.
        do_reset();
        set_vec(1, 9'o120);
        src_req = 4'b0010;
        step();
        src_req = 4'b0000;
        wait_irq();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 9; k++) begin
                step();
                chk("to_quiet", {31'd0, interrupt_request}, 32'd0);
            end
            step();
            chk("to_repulse", {31'd0, interrupt_request}, 32'd1);
        end
        serve(1, 9'o120, 2, 4'b0000, 4'b0000);
        chk("to_busy_done", {31'd0, busy}, 32'd0);

        // Request on the acknowledge cycle is kept and serviced again.
        do_reset();
        set_vec(1, 9'o150);
        src_req = 4'b0010;
        step();
        src_req = 4'b0000;
        serve(1, 9'o150, 2, 4'b0000, 4'b0010);
        chk("collide_pend", {28'd0, pending}, 32'h2);
        serve(1, 9'o150, 1, 4'b0000, 4'b0000);
        chk("collide_clear", {28'd0, pending}, 32'd0);

        // Vector snapshot taken at grant.
        do_reset();
        set_vec(0, 9'o040);
        src_req = 4'b0001;
        step();
        src_req = 4'b0000;
        wait_irq();
        step();
        set_vec(0, 9'o044);
        step();
        step();
        drive_svc(0, 9'o040, 3, 4'b0000, 4'b0000);

        // Reset in the middle of DRIVE.
        do_reset();
        set_vec(2, 9'o330);
        src_req = 4'b0100;
        step();
        src_req = 4'b0000;
        wait_irq();
        step();
        assert_vector = 1'b1;
        step();
        step();
        chk("mid_vout_pre", {23'd0, vector_out}, 32'o330);
        #2 reset = 1'b1;
        #1;
        chk("mid_vout", {23'd0, vector_out}, 32'd0);
        chk("mid_pend", {28'd0, pending}, 32'd0);
        chk("mid_irq",  {31'd0, interrupt_request}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        #5 reset = 1'b0;
        assert_vector = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mid_no_ack", {28'd0, src_ack}, 32'd0);
            chk("mid_idle",   {31'd0, busy}, 32'd0);
        end

        // Reset during the REQ cycle.
        do_reset();
        src_req = 4'b1000;
        step();
        src_req = 4'b0000;
        wait_irq();
        #2 reset = 1'b1;
        #1;
        chk("req_rst_irq",  {31'd0, interrupt_request}, 32'd0);
        chk("req_rst_pend", {28'd0, pending}, 32'd0);
        #5 reset = 1'b0;
        step();
        chk("req_rst_idle", {31'd0, busy}, 32'd0);

        run_random(1500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
